// File: rtl/mp3_vol_sci_writer_if.sv
// Signal bundle between the volume SCI writer and its surroundings: the
// attenuation input, the bus-sharing handshake, decoder DREQ and the SCI pins.
interface mp3_vol_sci_writer_if;
    logic [7:0] VOLUME;
    logic       MP3_DREQ;
    logic       BUS_GNT;
    logic       BUS_REQ;
    logic       MP3_XCS;
    logic       MP3_SCK;
    logic       MP3_SI;
    logic       BUSY;
    logic       WR_DONE;

    // Writer side: consumes volume/handshake inputs, drives the SCI pins.
    modport slave (
        input  VOLUME,
        input  MP3_DREQ,
        input  BUS_GNT,
        output BUS_REQ,
        output MP3_XCS,
        output MP3_SCK,
        output MP3_SI,
        output BUSY,
        output WR_DONE
    );

    // Environment side: volume source, bus arbiter and decoder model.
    modport master (
        output VOLUME,
        output MP3_DREQ,
        output BUS_GNT,
        input  BUS_REQ,
        input  MP3_XCS,
        input  MP3_SCK,
        input  MP3_SI,
        input  BUSY,
        input  WR_DONE
    );
endinterface

// File: rtl/mp3_vol_sci_writer.sv
// Watches the volume attenuation value and, whenever it differs from the value
// last written, sends one 32-bit SCI write (opcode, address, left, right) to the
// MP3 decoder volume register. The serial bus is borrowed from the stream block
// via REQ/GNT and each frame waits for decoder DREQ before chip select drops.
module mp3_vol_sci_writer #(
    parameter logic [7:0] VOL_ADDR   = 8'h0B,
    parameter int         SCK_HALF   = 2,
    parameter logic [7:0] SCI_OPCODE = 8'h02
) (
    input  logic                        MP3_SCLK,
    input  logic                        RESET,
    mp3_vol_sci_writer_if.slave         bus
);

    // Half-period counter sized for SCK_HALF (at least one bit wide).
    localparam int            HW        = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_DREQ = 3'd2,
        S_SHIFT     = 3'd3,
        S_HOLD      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t        state_q, state_d;

    // Control registers.
    logic [7:0]    vol_sent_q, vol_sent_d;
    logic [HW-1:0] hcnt_q,     hcnt_d;
    logic [4:0]    bit_q,      bit_d;
    logic          xcs_q,      xcs_d;
    logic          sck_q,      sck_d;
    logic          si_q,       si_d;

    // Data registers (no reset needed: always loaded before use).
    logic [7:0]    vol_snap_q, vol_snap_d;
    logic [31:0]   shift_q,    shift_d;

    logic          pending;
    logic          half_end;
    logic          last_bit;
    logic [31:0]   frame;

    assign pending  = (bus.VOLUME != vol_sent_q);
    assign half_end = (hcnt_q == HALF_LAST);
    assign last_bit = (bit_q == 5'd31);
    assign frame    = {SCI_OPCODE, VOL_ADDR, vol_snap_q, vol_snap_q};

    // Serial pins come straight from flops: no input-to-output combinational path.
    assign bus.MP3_XCS = xcs_q;
    assign bus.MP3_SCK = sck_q;
    assign bus.MP3_SI  = si_q;

    // State register; reset aborts any frame in progress immediately.
    always_ff @(posedge MP3_SCLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (pending)          state_d = S_REQ;
            S_REQ:       if (bus.BUS_GNT)      state_d = S_WAIT_DREQ;
            S_WAIT_DREQ: if (bus.MP3_DREQ)     state_d = S_SHIFT;
            S_SHIFT:     if (half_end && sck_q && last_bit) state_d = S_HOLD;
            S_HOLD:      if (half_end)         state_d = S_DONE;
            S_DONE:                            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Handshake/status outputs decoded from the current state.
    always_comb begin
        bus.BUS_REQ = 1'b0;
        bus.BUSY    = 1'b0;
        bus.WR_DONE = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.BUSY = 1'b0;
            end
            S_REQ, S_WAIT_DREQ, S_SHIFT, S_HOLD: begin
                bus.BUS_REQ = 1'b1;
                bus.BUSY    = 1'b1;
            end
            S_DONE: begin
                bus.BUSY    = 1'b1;
                bus.WR_DONE = 1'b1;
            end
            default: begin
                bus.BUSY = 1'b1;
            end
        endcase
    end

    // Datapath next values: snapshot, frame load, SCK/SI sequencing, hold timing.
    always_comb begin
        vol_sent_d = vol_sent_q;
        vol_snap_d = vol_snap_q;
        shift_d    = shift_q;
        hcnt_d     = hcnt_q;
        bit_d      = bit_q;
        xcs_d      = xcs_q;
        sck_d      = sck_q;
        si_d       = si_q;
        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    vol_snap_d = bus.VOLUME;
                end
            end
            S_WAIT_DREQ: begin
                if (bus.MP3_DREQ) begin
                    shift_d = frame;
                    xcs_d   = 1'b0;
                    sck_d   = 1'b0;
                    si_d    = frame[31];
                    hcnt_d  = '0;
                    bit_d   = '0;
                end
            end
            S_SHIFT: begin
                if (half_end) begin
                    hcnt_d = '0;
                    if (!sck_q) begin
                        // Rising edge: decoder samples the bit already on SI.
                        sck_d = 1'b1;
                    end else begin
                        // Falling edge: the only place SI is allowed to move.
                        sck_d = 1'b0;
                        if (!last_bit) begin
                            shift_d = {shift_q[30:0], 1'b0};
                            si_d    = shift_q[30];
                            bit_d   = bit_q + 5'd1;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (half_end) begin
                    hcnt_d = '0;
                    xcs_d  = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                vol_sent_d = vol_snap_q;
            end
            default: begin
                xcs_d = 1'b1;
                sck_d = 1'b0;
            end
        endcase
    end

    // Control flops; reset returns the SCI pins to idle without a clock.
    always_ff @(posedge MP3_SCLK or negedge RESET) begin
        if (!RESET) begin
            vol_sent_q <= 8'h00;
            hcnt_q     <= '0;
            bit_q      <= '0;
            xcs_q      <= 1'b1;
            sck_q      <= 1'b0;
            si_q       <= 1'b0;
        end else begin
            vol_sent_q <= vol_sent_d;
            hcnt_q     <= hcnt_d;
            bit_q      <= bit_d;
            xcs_q      <= xcs_d;
            sck_q      <= sck_d;
            si_q       <= si_d;
        end
    end

    // Data flops: volume snapshot and frame shift register.
    always_ff @(posedge MP3_SCLK) begin
        vol_snap_q <= vol_snap_d;
        shift_q    <= shift_d;
    end

endmodule

// File: tb/tb_mp3_vol_sci_writer.sv
// Bench for the volume SCI writer: a negedge monitor rebuilds every SCI frame
// from SCK rising edges, and directed sequences compare frames, chip-select
// width, WR_DONE pulses and handshake levels against hand-computed values.
module tb_mp3_vol_sci_writer;

    logic clk;
    logic rst_n;

    mp3_vol_sci_writer_if bus ();

    mp3_vol_sci_writer #(
        .VOL_ADDR   (8'h0B),
        .SCK_HALF   (2),
        .SCI_OPCODE (8'h02)
    ) dut (
        .MP3_SCLK (clk),
        .RESET    (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Monitor state.
    logic [31:0] cap;
    int          nbits;
    int          lowc;
    logic        prev_xcs;
    logic        prev_sck;
    logic        prev_wr;
    int          wr_cnt        = 0;
    int          req_cycles    = 0;
    int          xcs_low_total = 0;
    logic [31:0] fq[$];
    int          lq[$];
    int          bq[$];

    typedef struct {
        logic [7:0]  vol;
        logic [31:0] frame;
        int          low;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", nm, act, exp);
        end
    endtask

    // Pops the oldest captured frame and compares content, bit count and XCS width.
    task automatic chk_frame(input string nm, input logic [31:0] exp);
        n_cmp++;
        if (fq.size() == 0) begin
            n_fail++;
            $display("FAIL %s: actual=no_frame required=%h", nm, exp);
        end else begin
            logic [31:0] f;
            int          l;
            int          b;
            f = fq.pop_front();
            l = lq.pop_front();
            b = bq.pop_front();
            if (f !== exp) begin
                n_fail++;
                $display("FAIL %s: actual=%h required=%h", nm, f, exp);
            end
            chk({nm, "_bits"}, b, 32);
            chk({nm, "_xcs_low"}, l, 130);
        end
    endtask

    task automatic wait_wr(input int target, input int maxc, input string nm);
        int c;
        c = 0;
        while (wr_cnt < target && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(nm, wr_cnt, target);
    endtask

    task automatic wait_xcs_low(input int maxc, input string nm);
        int c;
        c = 0;
        while (bus.MP3_XCS !== 1'b0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chkb(nm, bus.MP3_XCS, 1'b0);
    endtask

    task automatic clear_q();
        fq.delete();
        lq.delete();
        bq.delete();
    endtask

    // Frame capture on SCK rising edges while XCS is low; WR_DONE pulse bookkeeping.
    always @(negedge clk) begin
        if (!rst_n) begin
            cap      = '0;
            nbits    = 0;
            lowc     = 0;
            prev_xcs = 1'b1;
            prev_sck = 1'b0;
            prev_wr  = 1'b0;
        end else begin
            if (bus.MP3_XCS == 1'b0) begin
                lowc++;
                xcs_low_total++;
                if (bus.MP3_SCK && !prev_sck) begin
                    cap = {cap[30:0], bus.MP3_SI};
                    nbits++;
                end
            end
            if (bus.MP3_XCS && !prev_xcs) begin
                fq.push_back(cap);
                lq.push_back(lowc);
                bq.push_back(nbits);
                cap   = '0;
                nbits = 0;
                lowc  = 0;
            end
            if (bus.BUS_REQ) req_cycles++;
            if (bus.WR_DONE) begin
                wr_cnt++;
                chkb("wr_done_back_to_back", prev_wr, 1'b0);
            end
            prev_xcs = bus.MP3_XCS;
            prev_sck = bus.MP3_SCK;
            prev_wr  = bus.WR_DONE;
        end
    end

    // Global time limit.
    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int low0;
        int c;

        vt[0] = '{vol: 8'h08, frame: 32'h020B0808, low: 130};
        vt[1] = '{vol: 8'hFF, frame: 32'h020BFFFF, low: 130};
        vt[2] = '{vol: 8'h00, frame: 32'h020B0000, low: 130};
        vt[3] = '{vol: 8'h5A, frame: 32'h020B5A5A, low: 130};
        vt[4] = '{vol: 8'h00, frame: 32'h020B0000, low: 130};

        rst_n        = 1'b0;
        bus.VOLUME   = 8'h00;
        bus.BUS_GNT  = 1'b1;
        bus.MP3_DREQ = 1'b1;

        // Reset state.
        #12;
        chkb("rst_xcs",     bus.MP3_XCS, 1'b1);
        chkb("rst_sck",     bus.MP3_SCK, 1'b0);
        chkb("rst_si",      bus.MP3_SI,  1'b0);
        chkb("rst_bus_req", bus.BUS_REQ, 1'b0);
        chkb("rst_busy",    bus.BUSY,    1'b0);
        chkb("rst_wr_done", bus.WR_DONE, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // VOLUME equals power-on value: nothing must happen.
        repeat (1000) @(posedge clk);
        #1;
        chk("idle_req_cycles", req_cycles, 0);
        chk("idle_xcs_low",    xcs_low_total, 0);
        chk("idle_wr_done",    wr_cnt, 0);

        // Table of single-frame writes with GNT and DREQ both high.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            clear_q();
            base = wr_cnt;
            bus.VOLUME = vt[i].vol;
            @(posedge clk); #1;
            chkb("vec_bus_req_rise", bus.BUS_REQ, 1'b1);
            wait_wr(base + 1, 400, "vec_wr_done");
            chkb("vec_bus_req_at_done", bus.BUS_REQ, 1'b0);
            repeat (5) @(negedge clk);
            chk("vec_single_pulse", wr_cnt, base + 1);
            n_cmp++;
            if (fq.size() == 0 || fq[0] !== vt[i].frame || lq[0] != vt[i].low || bq[0] != 32) begin
                n_fail++;
                $display("FAIL vec[%0d]: actual=%h/%0d/%0d required=%h/%0d/32", i,
                         (fq.size() > 0) ? fq[0] : 32'hx, (lq.size() > 0) ? lq[0] : -1,
                         (bq.size() > 0) ? bq[0] : -1, vt[i].frame, vt[i].low);
            end
        end

        // Grant withheld, then DREQ withheld: XCS must stay high until DREQ rises.
        @(posedge clk); #1;
        clear_q();
        base         = wr_cnt;
        low0         = xcs_low_total;
        bus.BUS_GNT  = 1'b0;
        bus.MP3_DREQ = 1'b0;
        bus.VOLUME   = 8'h10;
        repeat (50) @(posedge clk);
        #1;
        chkb("nognt_bus_req", bus.BUS_REQ, 1'b1);
        chkb("nognt_busy",    bus.BUSY,    1'b1);
        chk("nognt_xcs_low",  xcs_low_total, low0);
        bus.BUS_GNT = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chkb("nodreq_bus_req", bus.BUS_REQ, 1'b1);
        chkb("nodreq_xcs",     bus.MP3_XCS, 1'b1);
        chk("nodreq_xcs_low",  xcs_low_total, low0);
        bus.MP3_DREQ = 1'b1;
        wait_wr(base + 1, 400, "dreq_wr_done");
        chk_frame("dreq_frame", 32'h020B1010);

        // Volume change mid-shift: current frame unchanged, second frame follows.
        @(posedge clk); #1;
        clear_q();
        base       = wr_cnt;
        bus.VOLUME = 8'h08;
        wait_xcs_low(100, "mid_xcs_low");
        repeat (20) @(posedge clk);
        #1 bus.VOLUME = 8'h10;
        wait_wr(base + 2, 800, "mid_two_wr_done");
        repeat (20) @(negedge clk);
        chk("mid_no_third", wr_cnt, base + 2);
        chk_frame("mid_frame1", 32'h020B0808);
        chk_frame("mid_frame2", 32'h020B1010);

        // Reset mid-frame at bit 12: immediate idle, then a fresh full frame.
        @(posedge clk); #1;
        clear_q();
        base       = wr_cnt;
        bus.VOLUME = 8'h18;
        wait_xcs_low(100, "rstmid_xcs_low");
        c = 0;
        while (nbits < 12 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("rstmid_reach_bit12", nbits, 12);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chkb("rstmid_xcs",     bus.MP3_XCS, 1'b1);
        chkb("rstmid_sck",     bus.MP3_SCK, 1'b0);
        chkb("rstmid_bus_req", bus.BUS_REQ, 1'b0);
        chkb("rstmid_busy",    bus.BUSY,    1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_wr(base + 1, 400, "rstmid_wr_done");
        chk_frame("rstmid_frame", 32'h020B1818);
        chk("rstmid_one_frame", fq.size(), 0);

        // Bring vol_sent back to 0.
        @(posedge clk); #1;
        clear_q();
        base       = wr_cnt;
        bus.VOLUME = 8'h00;
        wait_wr(base + 1, 400, "zero_wr_done");
        chk_frame("zero_frame", 32'h020B0000);

        // Snapshot 0x08 taken, VOLUME returns to 0 before grant: two frames.
        bus.BUS_GNT = 1'b0;
        @(posedge clk); #1;
        clear_q();
        base       = wr_cnt;
        bus.VOLUME = 8'h08;
        @(posedge clk); #1;
        chkb("ret_bus_req", bus.BUS_REQ, 1'b1);
        bus.VOLUME = 8'h00;
        repeat (10) @(posedge clk);
        #1 bus.BUS_GNT = 1'b1;
        wait_wr(base + 2, 800, "ret_two_wr_done");
        chk_frame("ret_frame1", 32'h020B0808);
        chk_frame("ret_frame2", 32'h020B0000);
        repeat (50) @(negedge clk);
        chk("ret_settled_wr", wr_cnt, base + 2);
        chkb("ret_settled_busy", bus.BUSY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mp3_vol_sci_writer.md
Name: mp3_vol_sci_writer

Overview:
- Downstream consumer of the 8-bit attenuation value produced by the volume-adjust stage.
- Detects any change of VOLUME and writes it to the MP3 decoder's SCI volume register as one 32-bit SCI write frame: opcode 0x02, address VOL_ADDR, left = VOLUME, right = VOLUME.
- Shares the decoder serial bus with the data-stream block through a REQ/GNT handshake.
- Waits for decoder DREQ before each frame.

Parameters:
- VOL_ADDR, 8'h0B, SCI register address written.
- SCK_HALF, 2, MP3_SCLK cycles per SCK half-period (>=1).
- SCI_OPCODE, 8'h02, SCI write instruction byte.

Ports:
- MP3_SCLK  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- VOLUME  in  8  requested attenuation, 0 = loudest.
- MP3_DREQ  in  1  decoder ready; high = may accept SCI.
- BUS_GNT  in  1  stream block has released the serial bus.
- BUS_REQ  out  1  request for the serial bus.
- MP3_XCS  out  1  SCI chip select, active low.
- MP3_SCK  out  1  serial clock, idle low.
- MP3_SI  out  1  serial data to decoder, MSB first.
- BUSY  out  1  high in any state other than IDLE.
- WR_DONE  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State=IDLE; XCS=1, SCK=0, SI=0, BUS_REQ=0, BUSY=0, WR_DONE=0.
  - vol_sent=8'h00, matching the decoder's power-on value, so no write is issued after reset unless VOLUME differs from 0.
  - Reset asserted mid-frame aborts the frame immediately. Outputs reach idle without waiting for a clock.
- pending = (VOLUME != vol_sent), evaluated combinationally.
- States:
  - IDLE: if pending, snapshot VOLUME into vol_snap and go to REQ.
  - REQ: BUS_REQ=1; on BUS_GNT=1 go to WAIT_DREQ. BUS_GNT is sampled only in this state; later deassertion is ignored and the frame completes.
  - WAIT_DREQ: BUS_REQ stays 1; on MP3_DREQ=1 load shift_reg = {SCI_OPCODE, VOL_ADDR, vol_snap, vol_snap}, drive XCS=0 and SI=shift_reg[31], go to SHIFT.
  - SHIFT: each bit is SCK low for SCK_HALF cycles, then high for SCK_HALF cycles. SI changes only at the high-to-low SCK transition (the decoder samples on the rising edge). After 32 bits go to HOLD with SCK=0. SHIFT lasts exactly 64*SCK_HALF cycles.
  - HOLD: XCS stays 0 for SCK_HALF cycles with SCK=0, then XCS=1 and go to DONE.
  - DONE (one cycle): vol_sent<=vol_snap, WR_DONE=1, BUS_REQ=0, return to IDLE.
- Latency, from the GNT/DREQ condition to XCS rising: 64*SCK_HALF + SCK_HALF + 1 cycles (XCS low for 65*SCK_HALF cycles).
- VOLUME changing during REQ/WAIT_DREQ/SHIFT/HOLD: the frame carries vol_snap unchanged. In IDLE, pending re-evaluates against the new vol_sent and a second frame follows; the intermediate value is not required to be sent.
- VOLUME returning to vol_sent before IDLE samples it: no write.
- DREQ low in WAIT_DREQ: wait indefinitely with XCS=1. DREQ is not checked again once SHIFT has started.
- Outputs MP3_XCS, MP3_SCK, MP3_SI are registered, with no combinational path from inputs.
- WR_DONE is never asserted in back-to-back cycles; at least REQ and WAIT_DREQ lie between frames.

Test Plan:
- Reset release with VOLUME=0, GNT=1, DREQ=1 for 1000 cycles -> BUS_REQ stays 0, XCS stays 1, no WR_DONE.
- VOLUME 0x00->0x08, GNT=1, DREQ=1, SCK_HALF=2 -> BUS_REQ=1; SI bits sampled at SCK rising edges equal 0x020B0808; XCS low 130 cycles; one WR_DONE pulse; BUS_REQ=0 after it.
- VOLUME 0x00->0x10 with GNT=0 for 50 cycles, then GNT=1 and DREQ=0 for 30 cycles, then DREQ=1 -> XCS stays 1 until DREQ rises; frame carries 0x020B1010.
- VOLUME 0x08->0x10 mid-SHIFT (current frame 0x08) -> first frame 0x020B0808, WR_DONE, then a second frame 0x020B1010, exactly two WR_DONE pulses.
- RESET low for 1 cycle at bit 12 of a frame -> XCS=1, SCK=0, BUS_REQ=0 at once; after release with VOLUME still 0x18, a full fresh frame 0x020B1818 is sent.
- Set VOLUME 0x08 and return it to 0x00 while in IDLE with GNT=0 after snapshot -> frame carries 0x08, then a second frame carries 0x00 (pending vs vol_sent=0x08).
